// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the 8N1 UART transmitter.
//   uart_state_e          - transmitter FSM states
//   DATA_BITS            - payload bits per frame
//   DEFAULT_CLKS_PER_BIT - default system clocks per serial bit
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } uart_state_e;

endpackage

// File: rtl/uart_transmit_if.sv
// uart_transmit_if: producer-to-transmitter handshake plus the serial line.
//   T_EN          - level-sensitive transmit request (producer -> tx)
//   Data          - byte to send, sampled at frame start (producer -> tx)
//   Serial        - TX line, idles high (tx -> board)
//   Transmit_Done - one-cycle end-of-frame strobe (tx -> producer)
// Modports: master = producer side, slave = transmitter side.
interface uart_transmit_if;
  import uart_pkg::*;

  logic                 T_EN;
  logic [DATA_BITS-1:0] Data;
  logic                 Serial;
  logic                 Transmit_Done;

  modport master (
    output T_EN,
    output Data,
    input  Serial,
    input  Transmit_Done
  );

  modport slave (
    input  T_EN,
    input  Data,
    output Serial,
    output Transmit_Done
  );
endinterface

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: bit-period timer, counts 0..CLKS_PER_BIT-1 and wraps.
//   Clk     - system clock
//   reset   - asynchronous active-high reset
//   clear   - synchronous clear, holds the count at 0
//   bit_end - high during the last clock of each bit period
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic Clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);
  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign bit_end = (count == LAST);
endmodule

// File: rtl/uart_transmit.sv
// uart_transmit: 8N1 serial transmitter. Frames a byte as start bit, eight
// data bits LSB-first and a stop bit, then pulses Transmit_Done for one
// cycle. Holding T_EN high streams back-to-back frames (period 10N+2).
//   Clk   - system clock
//   reset - asynchronous active-high reset
//   bus   - uart_transmit_if.slave (T_EN, Data in; Serial, Transmit_Done out)
module uart_transmit
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input logic            Clk,
  input logic            reset,
  uart_transmit_if.slave bus
);
  uart_state_e          state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [2:0]           bit_idx;
  logic                 bit_end;
  logic                 baud_clear;

  // Baud timer only runs while a bit is on the line, so each bit period
  // starts from zero right after the start edge.
  assign baud_clear = (state == IDLE) || (state == DONE);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .Clk     (Clk),
    .reset   (reset),
    .clear   (baud_clear),
    .bit_end (bit_end)
  );

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      shift_reg         <= '0;
      bit_idx           <= '0;
      bus.Serial        <= 1'b1;
      bus.Transmit_Done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.Serial        <= 1'b1;
          bus.Transmit_Done <= 1'b0;
          if (bus.T_EN) begin
            shift_reg  <= bus.Data;
            bit_idx    <= '0;
            bus.Serial <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          if (bit_end) begin
            bus.Serial <= shift_reg[0];
            state      <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              bus.Serial <= 1'b1;
              state      <= STOP;
            end else begin
              // Registered output: drive the next bit directly rather than
              // waiting a cycle for the shifted value.
              shift_reg  <= shift_reg >> 1;
              bus.Serial <= shift_reg[1];
              bit_idx    <= bit_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            bus.Transmit_Done <= 1'b1;
            state             <= DONE;
          end
        end
        DONE: begin
          bus.Serial        <= 1'b1;
          bus.Transmit_Done <= 1'b0;
          state             <= IDLE;
        end
        default: begin
          bus.Serial        <= 1'b1;
          bus.Transmit_Done <= 1'b0;
          state             <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_transmit.sv
// tb_uart_transmit: directed-plus-random bench for uart_transmit with
// CLKS_PER_BIT=4. Expected line levels come from a per-frame bit list
// {stop, data[7:0], start} indexed by elapsed cycles / N.
module tb_uart_transmit;
  localparam int N = 4;

  logic Clk;
  logic reset;
  int   errors;
  int   checks;

  uart_transmit_if bus ();

  uart_transmit #(
    .CLKS_PER_BIT(N)
  ) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_serial"}, {7'd0, bus.Serial}, 8'd1);
    chk({tag, "_done"}, {7'd0, bus.Transmit_Done}, 8'd0);
  endtask

  // Called #1 after an edge, with the next edge being the start edge E.
  // Checks every cycle 1..10N+1 after E. act_kind at cycle act_cycle:
  // 1 = change Data to act_data, 2 = drop T_EN, 3 = stop checking (abort).
  task automatic check_frame(input logic [7:0] b, input int act_cycle,
                             input int act_kind, input logic [7:0] act_data);
    logic [9:0] frame;
    logic       exp_ser;
    logic       exp_done;
    frame = {1'b1, b, 1'b0};
    for (int c = 1; c <= 10 * N + 1; c++) begin
      tick();
      exp_ser  = (c <= 10 * N) ? frame[(c - 1) / N] : 1'b1;
      exp_done = (c == 10 * N + 1);
      chk($sformatf("serial_%02h_c%0d", b, c), {7'd0, bus.Serial}, {7'd0, exp_ser});
      chk($sformatf("done_%02h_c%0d", b, c), {7'd0, bus.Transmit_Done}, {7'd0, exp_done});
      if (c == act_cycle) begin
        case (act_kind)
          1: bus.Data = act_data;
          2: bus.T_EN = 1'b0;
          3: return;
          default: ;
        endcase
      end
    end
  endtask

  initial begin
    logic [7:0] nxt;
    logic [7:0] r;
    errors = 0;
    checks = 0;

    // 1: reset held, outputs at idle levels
    reset    = 1'b1;
    bus.T_EN = 1'b0;
    bus.Data = 8'd62;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle($sformatf("reset_hold%0d", i));
    end

    // 2: release reset with T_EN high, first frame of 62
    bus.T_EN = 1'b1;
    reset    = 1'b0;
    check_frame(8'd62, 0, 0, 8'd0);

    // 3: streaming, next byte supplied on each done strobe
    nxt = 8'd62;
    for (int f = 0; f < 3; f++) begin
      nxt      = nxt + 8'd1;
      bus.Data = nxt;
      tick();
      chk_idle($sformatf("gap_stream%0d", f));
      check_frame(nxt, 0, 0, 8'd0);
    end

    // random bytes streamed back to back
    for (int f = 0; f < 4; f++) begin
      r        = 8'($urandom_range(0, 255));
      bus.Data = r;
      tick();
      chk_idle($sformatf("gap_rand%0d", f));
      check_frame(r, 0, 0, 8'd0);
    end

    // 4: Data changes mid-frame; in-flight frame unaffected
    bus.Data = 8'h00;
    tick();
    chk_idle("gap_zero");
    check_frame(8'h00, 2 * N + 2, 1, 8'hFF);
    tick();
    chk_idle("gap_ff");
    check_frame(8'hFF, 0, 0, 8'd0);

    // 5: drop T_EN during bit 3; frame completes, then stays idle
    r        = 8'($urandom_range(0, 255));
    bus.Data = r;
    tick();
    chk_idle("gap_drop");
    check_frame(r, 4 * N + 2, 2, 8'd0);
    for (int i = 0; i < 3 * N; i++) begin
      tick();
      chk_idle($sformatf("idle_after_drop%0d", i));
    end

    // 6: reset during bit 5, asynchronous return to idle, then fresh frame
    r        = 8'($urandom_range(0, 255)) | 8'h20;
    bus.Data = r;
    bus.T_EN = 1'b1;
    check_frame(r, 6 * N + 2, 3, 8'd0);
    #3;
    reset = 1'b1;
    #1;
    chk_idle("async_reset");
    r        = 8'($urandom_range(0, 255));
    bus.Data = r;
    tick();
    chk_idle("reset_held_a");
    tick();
    chk_idle("reset_held_b");
    reset = 1'b0;
    check_frame(r, 0, 0, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_transmit.md
# uart_transmit

Byte-wide asynchronous serial transmitter (8N1) driving the board's UART TX line. On request it frames a parallel byte as start bit, eight data bits LSB-first and one stop bit at a fixed baud derived from the system clock, then pulses a done strobe. Holding the enable high streams back-to-back frames, with the producer supplying the next byte on each done strobe.

## Interface
- `CLKS_PER_BIT`, default 16: system clocks per serial bit (baud = f_Clk / CLKS_PER_BIT); legal range ≥ 2.
- `Clk` input, 1 bit: system clock, all state updates on its rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `T_EN` input, 1 bit: transmit enable, level-sensitive request.
- `Data` input, 8 bits: byte to send, sampled only at frame start.
- `Serial` output, 1 bit: TX line, idles high.
- `Transmit_Done` output, 1 bit: one-cycle strobe marking frame completion.
- One clock; reset is asynchronous and active-high.

## Operation
- FSM states: IDLE, START, DATA, STOP, DONE.
- IDLE: `Serial`=1. If `T_EN`=1 at a rising edge, latch `Data` into the shift register, clear the bit counter and the baud counter, and go to START.
- START: `Serial`=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: `Serial` = shift-register bit 0. Each bit is held CLKS_PER_BIT cycles, then the register shifts right. After bit index 7 go to STOP.
- STOP: `Serial`=1 for CLKS_PER_BIT cycles, then DONE.
- DONE: `Serial`=1, `Transmit_Done`=1 for exactly this cycle, then IDLE unconditionally.
- `Data` changes after latching have no effect on the frame in flight.
- Deasserting `T_EN` mid-frame does not abort it; the frame completes and the FSM then stays in IDLE.
- `T_EN` held high gives continuous frames; the byte present in the IDLE cycle after DONE is sent next.
- Reset, at any time including mid-frame: go to IDLE immediately, `Serial`=1, `Transmit_Done`=0, all counters and the shift register cleared. The partial frame is lost.

## Timing
- Reset values: `Serial`=1, `Transmit_Done`=0.
- All outputs are registered; no combinational path from inputs to outputs.
- Edge E, with `T_EN`=1 in IDLE: `Serial` falls after E.
  - Start bit occupies cycles 1..N after E (N = CLKS_PER_BIT).
  - Data bit k occupies cycles (k+1)N+1 .. (k+2)N.
  - Stop bit occupies cycles 9N+1 .. 10N.
  - `Transmit_Done` is high in cycle 10N+1.
- Back-to-back frame period is 10N+2 cycles: a two-cycle high gap (DONE + IDLE) beyond the stop bit.
- Baud counter width is clog2(CLKS_PER_BIT); it wraps to 0 at CLKS_PER_BIT−1. Bit counter is 3 bits.

## Structure
- Package `uart_pkg`: the state enum (IDLE, START, DATA, STOP, DONE) and constants DATA_BITS=8 and the default CLKS_PER_BIT.
- One natural sub-module, `uart_baud_counter`:
  - counts 0..CLKS_PER_BIT−1, clearable;
  - emits a `bit_end` pulse on the last count.
- FSM, shift register and bit counter live in the top module.

## Test plan
All scenarios use CLKS_PER_BIT=4.
1. Reset held, `T_EN`=0, `Data`=62 → `Serial`=1 and `Transmit_Done`=0 throughout; assert reset mid-cycle → outputs return to these values without waiting for a clock.
2. Release reset with `T_EN`=1 and `Data`=62 (0x3E) → `Serial` sequence, one bit per 4 cycles: 0 | 0,1,1,1,1,1,0,0 | 1; `Transmit_Done` high exactly one cycle, 41 cycles after the start edge.
3. `T_EN` held high; `Data` incremented on each `Transmit_Done` rising edge → frames carry 62, 63, 64, … at a period of 42 cycles with no missed or repeated byte.
4. Change `Data` to 0xFF during the DATA state of a 0x00 frame → the frame still sends all-zero data bits; 0xFF goes in the next frame.
5. Drop `T_EN` in the middle of bit 3 → the frame completes with a single `Transmit_Done` pulse; the FSM then stays IDLE with `Serial`=1.
6. Assert reset during bit 5 → `Serial`=1 at once; after release with `T_EN`=1 a fresh frame starts with the start bit of the current `Data`.
